rr_stream_arbiter: RTL and testbench
====================================

// Module: rr_stream_arbiter
// PURPOSE
//  Shares one downstream valid/ready stream (e.g. a 2-entry handshake buffer input) among
//  NUM_REQ upstream requesters. Round-robin arbitration with packet lock: once a requester
//  wins, it owns the channel until its beat with up_last=1 is accepted.
//  Datapath is combinational (grant mux); arbitration state is registered.
// PARAMETERS
//  NUM_REQ     4    number of requesters, >=2
//  WORD_WIDTH  32   data width per beat
//  IDX_W       $clog2(NUM_REQ)  grant index width (derived, not overridden)
// PORTS
//  clk          in   1                   clock, rising edge
//  rst_n        in   1                   reset, synchronous, active-low
//  up_valid     in   NUM_REQ             per-requester valid
//  up_data      in   NUM_REQ*WORD_WIDTH  requester i data at [i*WORD_WIDTH +: WORD_WIDTH]
//  up_last      in   NUM_REQ             per-requester last-beat-of-packet flag
//  up_ready     out  NUM_REQ             per-requester ready (one-hot or zero)
//  down_valid   out  1                   merged stream valid
//  down_data    out  WORD_WIDTH          merged stream data
//  down_last    out  1                   merged stream last
//  down_ready   in   1                   downstream ready
//  grant_idx    out  IDX_W               current owner index (valid when down_valid=1)
//  busy         out  1                   1 while in LOCKED state
//  pkt_count    out  16                  count of completed packets, wraps 0xFFFF->0
// BEHAVIOUR
//  State: IDLE / LOCKED; regs: state, rr_ptr (last served), lock_idx, pkt_count.
//  Reset: state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has first priority), lock_idx=0,
//   pkt_count=0. With all up_valid=0 after reset: down_valid=0, up_ready=0, busy=0.
//  IDLE: pick = first i with up_valid[i]=1 scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
//   down_valid=|up_valid; grant_idx=pick; down_data/down_last = pick's data/last;
//   up_ready[pick]=down_ready, all other up_ready=0.
//  LOCKED: grant_idx=lock_idx; down_valid=up_valid[lock_idx]; only up_ready[lock_idx]
//   may be 1 (=down_ready). Other requesters' valid ignored; no arbitration.
//  Transfer = down_valid & down_ready (zero-latency pass-through, no buffering).
//  IDLE, transfer, last=0 -> LOCKED, lock_idx<=pick.
//  IDLE, transfer, last=1 -> stay IDLE (1-beat packet), rr_ptr<=pick, pkt_count+1.
//  LOCKED, transfer, last=1 -> IDLE, rr_ptr<=lock_idx, pkt_count+1.
//  No transfer -> no state change; rr_ptr advances only on packet completion.
//  Owner dropping up_valid mid-packet (bubble): lock held, down_valid=0 until it resumes.
//  IDLE with requests but down_ready=0: pick may change cycle to cycle as up_valid changes;
//   committed only on transfer (down_valid never asserted with data from a non-pick).
//  Back-to-back: packet completion and next packet's first beat may not share a cycle;
//   next IDLE cycle arbitrates with the updated rr_ptr, so no dead cycle beyond that one.
//  Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
//  Reset asserted mid-packet: state->IDLE immediately, partial packet abandoned.
//  Requesters must hold valid/data/last stable until ready (AXI-stream rule).
// TESTING
//  T1 reset, all up_valid=0 -> down_valid=0, up_ready=0, busy=0, pkt_count=0.
//  T2 NUM_REQ=4, all valid, 1-beat packets, down_ready=1 -> grant_idx 0,1,2,3,0; pkt_count 5.
//  T3 req1 3-beat packet (last on beat 3), req2 valid throughout -> req2 gets no ready
//     until req1 beat 3 accepted; then grant_idx=2; busy=1 during beats 2-3 window.
//  T4 req0 mid-packet drops valid 2 cycles, req3 valid -> down_valid=0 2 cycles, lock kept.
//  T5 down_ready toggling 1/0 during 4-beat packet -> data order A,B,C,D, no loss/duplication.
//  T6 assert rst_n=0 mid-packet from req2 -> next cycle IDLE, rr_ptr=3, req0 wins next.

Source files
------------

// File: rtl/rr_stream_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready streams onto one output stream.
// Once a requester wins, it keeps the output until its last beat is accepted.
module rr_stream_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 32,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            up_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] up_data,
  input  logic [NUM_REQ-1:0]            up_last,
  output logic [NUM_REQ-1:0]            up_ready,
  output logic                          down_valid,
  output logic [WORD_WIDTH-1:0]         down_data,
  output logic                          down_last,
  input  logic                          down_ready,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy,
  output logic [15:0]                   pkt_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;

  logic [IDX_W-1:0]      pick;
  logic [IDX_W-1:0]      sel;
  logic                  any_valid;
  logic                  xfer;
  logic [WORD_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = up_data[g*WORD_WIDTH +: WORD_WIDTH];
  end

  // Descending scan so the nearest requester after ptr wins.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [IDX_W-1:0]   ptr,
    input logic [NUM_REQ-1:0] v
  );
    logic [IDX_W-1:0] r;
    int               j;
    r = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (v[j]) r = IDX_W'(j);
    end
    return r;
  endfunction

  assign any_valid = |up_valid;
  assign pick      = rr_pick(rr_ptr_q, up_valid);

  always_comb begin
    sel        = pick;
    down_valid = any_valid;
    up_ready   = '0;
    unique case (1'b1)
      (state_q == LOCKED): begin
        sel           = lock_idx_q;
        down_valid    = up_valid[lock_idx_q];
        up_ready[sel] = down_ready;
      end
      default: begin
        up_ready[sel] = down_ready & any_valid;
      end
    endcase
  end

  assign down_data = data_arr[sel];
  assign down_last = up_last[sel];
  assign grant_idx = sel;
  assign busy      = (state_q == LOCKED);
  assign pkt_count = pkt_cnt_q;
  assign xfer      = down_valid & down_ready;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && down_last) begin
          rr_ptr_d  = pick;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else if (xfer) begin
          state_d    = LOCKED;
          lock_idx_d = pick;
        end
      end
      LOCKED: begin
        if (xfer && down_last) begin
          state_d   = IDLE;
          rr_ptr_d  = lock_idx_q;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      lock_idx_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed checks for rr_stream_arbiter with four requesters.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
module tb_rr_stream_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   up_valid;
  logic [127:0] up_data;
  logic [3:0]   up_last;
  logic [3:0]   up_ready;
  logic         down_valid;
  logic [31:0]  down_data;
  logic         down_last;
  logic         down_ready;
  logic [1:0]   grant_idx;
  logic         busy;
  logic [15:0]  pkt_count;

  int checks = 0;
  int errors = 0;

  rr_stream_arbiter #(
    .NUM_REQ    (4),
    .WORD_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_last    (up_last),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_last  (down_last),
    .down_ready (down_ready),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int r, input logic [31:0] d);
    up_data[r*32 +: 32] = d;
  endtask

  logic [31:0] seq [4];
  logic [31:0] got_q [$];
  int          beat;
  int          nxfer;

  initial begin
    rst_n      = 1'b0;
    up_valid   = '0;
    up_data    = '0;
    up_last    = '0;
    down_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    // T1 reset state
    chk("t1_dvalid", 32'(down_valid), 32'd0);
    chk("t1_ready", 32'(up_ready), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_cnt", 32'(pkt_count), 32'd0);
    tick();

    // T2 all valid, 1-beat packets: rotation 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_data(i, 32'hA0 + i);
    up_valid   = 4'b1111;
    up_last    = 4'b1111;
    down_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t2_grant", 32'(grant_idx), k % 4);
      chk("t2_data", down_data, 32'hA0 + (k % 4));
      chk("t2_ready", 32'(up_ready), 32'd1 << (k % 4));
      tick();
    end
    #2;
    chk("t2_cnt", 32'(pkt_count), 32'd5);
    up_valid = '0;
    tick();

    // T3 req1 3-beat packet, req2 waiting (rr_ptr now 0)
    up_valid = 4'b0110;
    up_last  = 4'b0100;
    set_data(1, 32'h11);
    #2;
    chk("t3_b1_grant", 32'(grant_idx), 32'd1);
    chk("t3_b1_ready", 32'(up_ready), 32'b0010);
    chk("t3_b1_busy", 32'(busy), 32'd0);
    tick();
    set_data(1, 32'h12);
    #2;
    chk("t3_b2_busy", 32'(busy), 32'd1);
    chk("t3_b2_ready", 32'(up_ready), 32'b0010);
    chk("t3_b2_data", down_data, 32'h12);
    tick();
    set_data(1, 32'h13);
    up_last = 4'b0110;
    #2;
    chk("t3_b3_busy", 32'(busy), 32'd1);
    chk("t3_b3_ready", 32'(up_ready), 32'b0010);
    chk("t3_b3_last", 32'(down_last), 32'd1);
    tick();
    up_valid = 4'b0100;
    #2;
    chk("t3_post_grant", 32'(grant_idx), 32'd2);
    chk("t3_post_ready", 32'(up_ready), 32'b0100);
    chk("t3_post_busy", 32'(busy), 32'd0);
    chk("t3_post_cnt", 32'(pkt_count), 32'd6);
    tick();
    up_valid = '0;
    #2;
    chk("t3_cnt", 32'(pkt_count), 32'd7);
    tick();

    // T4 req0 bubble mid-packet with req3 waiting (rr_ptr now 2)
    up_valid = 4'b0001;
    up_last  = 4'b1000;
    set_data(0, 32'h40);
    set_data(3, 32'h43);
    #2;
    chk("t4_b1_grant", 32'(grant_idx), 32'd0);
    tick();
    up_valid = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("t4_bub_dvalid", 32'(down_valid), 32'd0);
      chk("t4_bub_grant", 32'(grant_idx), 32'd0);
      chk("t4_bub_busy", 32'(busy), 32'd1);
      chk("t4_bub_r3", 32'(up_ready[3]), 32'd0);
      tick();
    end
    up_valid = 4'b1001;
    up_last  = 4'b1001;
    set_data(0, 32'h41);
    #2;
    chk("t4_res_dvalid", 32'(down_valid), 32'd1);
    chk("t4_res_grant", 32'(grant_idx), 32'd0);
    chk("t4_res_data", down_data, 32'h41);
    tick();
    up_valid = 4'b1000;
    #2;
    chk("t4_r3_grant", 32'(grant_idx), 32'd3);
    chk("t4_r3_cnt", 32'(pkt_count), 32'd8);
    tick();
    up_valid = '0;
    #2;
    chk("t4_cnt", 32'(pkt_count), 32'd9);
    tick();

    // T5 req1 4-beat packet with down_ready toggling
    seq[0] = 32'hA;
    seq[1] = 32'hB;
    seq[2] = 32'hC;
    seq[3] = 32'hD;
    beat  = 0;
    nxfer = 0;
    up_valid = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      down_ready = (c % 2 == 0);
      set_data(1, seq[beat]);
      up_last = (beat == 3) ? 4'b0010 : 4'b0000;
      #2;
      if (down_valid && down_ready) got_q.push_back(down_data);
      if (up_ready[1] && up_valid[1]) begin
        nxfer++;
        beat++;
      end
      tick();
      if (beat == 4) up_valid = '0;
    end
    chk("t5_nxfer", 32'(nxfer), 32'd4);
    chk("t5_qsize", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t5_order", (i < got_q.size()) ? got_q[i] : 32'hDEAD,
          32'hA + i);
    #2;
    chk("t5_cnt", 32'(pkt_count), 32'd10);
    chk("t5_busy", 32'(busy), 32'd0);
    down_ready = 1'b1;
    tick();

    // T6 reset mid-packet from req2 (rr_ptr now 1)
    up_valid = 4'b0100;
    up_last  = 4'b0000;
    set_data(2, 32'h62);
    #2;
    chk("t6_grant", 32'(grant_idx), 32'd2);
    tick();
    #2;
    chk("t6_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    up_valid = 4'b0101;
    #2;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_cnt", 32'(pkt_count), 32'd0);
    chk("t6_win_grant", 32'(grant_idx), 32'd0);
    chk("t6_win_ready", 32'(up_ready), 32'b0001);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
